// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//   SPI slave receiver. CS, SCK and MOSI are oversampled in the system clock
//   domain. All four SPI modes are selected by CPOL/CPHA. Words of DATA_W
//   bits, MSB first, are assembled. Each completed word is presented as a
//   one-cycle write strobe with an auto-incrementing address. The previous
//   word is echoed on MISO, and words truncated by CS rising are flagged.
//
//   Optional feature macro: SPI_SLAVE_RX_HEADER_EN
//     When this macro is defined, the first complete word of every frame is
//     an address header instead of data.
//
// Ports
//   clock        : system clock, the only clock in the block
//   reset        : asynchronous, active-high reset
//   cs           : SPI chip select, active low (asynchronous)
//   sck          : SPI clock (asynchronous)
//   mosi         : SPI data in (asynchronous)
//   miso         : SPI data out, the echo of the previous word
//   data         : last completed word
//   address      : write address for data
//   write_strobe : one-cycle pulse per completed word
//   frame_active : high while a frame is being received
//   frame_error  : sticky; set when CS rises mid-word, cleared at next CS fall
module spi_slave_rx #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs,
  input  logic              sck,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] address,
  output logic              write_strobe,
  output logic              frame_active,
  output logic              frame_error
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] BASE_M1  = ADDR_W'(BASE_ADDR - 1);
  localparam logic [2:0]        SCK_IDLE = (CPOL != 0) ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t state, state_next;

  logic [2:0]        cs_sync, sck_sync;
  logic [1:0]        mosi_sync;
  logic [DATA_W-1:0] shreg, shift_next, echo, tx_reg;
  logic [CNT_W-1:0]  bit_cnt, cnt_after;
  logic              cs_s, cs_fall, cs_rise, sck_rise, sck_fall;
  logic              leading, trailing, sample_edge, launch_edge;
  logic              frame_start, frame_end, last_bit, word_done;
`ifdef SPI_SLAVE_RX_HEADER_EN
  logic              header_pending;
`endif

  // CS resets to the "low" value so that WAIT_IDLE must observe a real high
  // level on the pin before any frame is accepted. SCK resets to its idle
  // level so that no edge is reported on reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_sync   <= 3'b000;
      sck_sync  <= SCK_IDLE;
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[1:0], cs};
      sck_sync  <= {sck_sync[1:0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  assign cs_s     = cs_sync[1];
  assign cs_fall  = cs_sync[2] & ~cs_sync[1];
  assign cs_rise  = ~cs_sync[2] & cs_sync[1];
  assign sck_rise = ~sck_sync[2] & sck_sync[1];
  assign sck_fall = sck_sync[2] & ~sck_sync[1];

  assign leading     = (CPOL == 0) ? sck_rise : sck_fall;
  assign trailing    = (CPOL == 0) ? sck_fall : sck_rise;
  assign sample_edge = (CPHA == 0) ? leading : trailing;
  assign launch_edge = (CPHA == 0) ? trailing : leading;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= WAIT_IDLE;
    else       state <= state_next;
  end

  // Next-state logic together with the frame start/end control pulses.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      WAIT_IDLE: if (cs_s) state_next = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_next  = SHIFT;
          frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  // cnt_after is the bit count once this cycle's sample edge (if any) is
  // applied. This lets a CS rise in the same cycle see the completed word.
  assign shift_next = {shreg[DATA_W-2:0], mosi_sync[1]};
  assign last_bit   = (bit_cnt == LAST_BIT);
  assign word_done  = (state == SHIFT) && sample_edge && last_bit;
  assign cnt_after  = sample_edge ? (last_bit ? '0 : bit_cnt + 1'b1) : bit_cnt;

  // Receive datapath, word output, echo/MISO shifter and the frame flags.
  // On a launch edge with a zero bit count a new word is starting, so the
  // echo is reloaded. Otherwise the transmit register shifts. With CPHA=0
  // the first bit has no launch edge, so the echo is loaded at frame start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg          <= '0;
      bit_cnt        <= '0;
      echo           <= '0;
      tx_reg         <= '0;
      data           <= '0;
      address        <= BASE_M1;
      write_strobe   <= 1'b0;
      frame_active   <= 1'b0;
      frame_error    <= 1'b0;
`ifdef SPI_SLAVE_RX_HEADER_EN
      header_pending <= 1'b0;
`endif
    end else begin
      write_strobe <= 1'b0;
      if (frame_start) begin
        bit_cnt        <= '0;
        address        <= BASE_M1;
        frame_error    <= 1'b0;
        frame_active   <= 1'b1;
`ifdef SPI_SLAVE_RX_HEADER_EN
        header_pending <= 1'b1;
`endif
        if (CPHA == 0) tx_reg <= echo;
      end else if (state == SHIFT) begin
        if (sample_edge) begin
          shreg   <= shift_next;
          bit_cnt <= cnt_after;
        end
        if (word_done) begin
          echo <= shift_next;
`ifdef SPI_SLAVE_RX_HEADER_EN
          if (header_pending) begin
            header_pending <= 1'b0;
            address        <= ADDR_W'(shift_next) - 1'b1;
          end else begin
            data         <= shift_next;
            address      <= address + 1'b1;
            write_strobe <= 1'b1;
          end
`else
          data         <= shift_next;
          address      <= address + 1'b1;
          write_strobe <= 1'b1;
`endif
        end
        if (launch_edge) begin
          if (bit_cnt == '0) tx_reg <= echo;
          else               tx_reg <= {tx_reg[DATA_W-2:0], 1'b0};
        end
        if (frame_end) begin
          frame_active <= 1'b0;
          if (cnt_after != '0) frame_error <= 1'b1;
        end
      end
    end
  end

  assign miso = (state == SHIFT) & tx_reg[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx
//   Directed bench for spi_slave_rx. Four instances cover SPI modes 0..3.
//   The mode-1 instance uses a 2-bit address so that wrap can be exercised.
//   A behavioural SPI master drives each instance in turn. Write strobes are
//   collected into per-instance queues and compared against hand-computed
//   address/data pairs.
module tb_spi_slave_rx;

  localparam time CLK_HALF = 5ns;
  localparam time HALF     = 80ns;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cs_v  = 4'b1111;
  logic [3:0]  sck_v = 4'b1100;
  logic        mosi  = 1'b0;
  logic [3:0]  miso_v, ws_v, fa_v, fe_v;
  logic [15:0] data0, data1, data2, data3;
  logic [10:0] addr0, addr2, addr3;
  logic [1:0]  addr1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q0[$], q1[$], q2[$], q3[$];
  logic [15:0] rx;

  always #CLK_HALF clock = ~clock;

  spi_slave_rx #(.DATA_W(16), .ADDR_W(11), .BASE_ADDR(0), .CPOL(0), .CPHA(0)) dut0 (
    .clock(clock), .reset(reset), .cs(cs_v[0]), .sck(sck_v[0]), .mosi(mosi),
    .miso(miso_v[0]), .data(data0), .address(addr0), .write_strobe(ws_v[0]),
    .frame_active(fa_v[0]), .frame_error(fe_v[0]));

  spi_slave_rx #(.DATA_W(16), .ADDR_W(2), .BASE_ADDR(0), .CPOL(0), .CPHA(1)) dut1 (
    .clock(clock), .reset(reset), .cs(cs_v[1]), .sck(sck_v[1]), .mosi(mosi),
    .miso(miso_v[1]), .data(data1), .address(addr1), .write_strobe(ws_v[1]),
    .frame_active(fa_v[1]), .frame_error(fe_v[1]));

  spi_slave_rx #(.DATA_W(16), .ADDR_W(11), .BASE_ADDR(0), .CPOL(1), .CPHA(0)) dut2 (
    .clock(clock), .reset(reset), .cs(cs_v[2]), .sck(sck_v[2]), .mosi(mosi),
    .miso(miso_v[2]), .data(data2), .address(addr2), .write_strobe(ws_v[2]),
    .frame_active(fa_v[2]), .frame_error(fe_v[2]));

  spi_slave_rx #(.DATA_W(16), .ADDR_W(11), .BASE_ADDR(0), .CPOL(1), .CPHA(1)) dut3 (
    .clock(clock), .reset(reset), .cs(cs_v[3]), .sck(sck_v[3]), .mosi(mosi),
    .miso(miso_v[3]), .data(data3), .address(addr3), .write_strobe(ws_v[3]),
    .frame_active(fa_v[3]), .frame_error(fe_v[3]));

  // Strobe collectors, sampled away from the active clock edge.
  always @(negedge clock) if (ws_v[0]) q0.push_back({5'd0, addr0, data0});
  always @(negedge clock) if (ws_v[1]) q1.push_back({14'd0, addr1, data1});
  always @(negedge clock) if (ws_v[2]) q2.push_back({5'd0, addr2, data2});
  always @(negedge clock) if (ws_v[3]) q3.push_back({5'd0, addr3, data3});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      2:       return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [31:0] q_pop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      2:       return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic expect_strobe(input string tag, input int k, input int ea, input logic [15:0] ed);
    logic [31:0] got;
    int          sz;
    sz = q_size(k);
    check({tag, "_present"}, 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      got = q_pop(k);
      check({tag, "_addr"}, {16'd0, got[31:16]}, 32'(ea));
      check({tag, "_data"}, {16'd0, got[15:0]}, {16'd0, ed});
    end
  endtask

  task automatic expect_no_strobe(input string tag, input int k);
    check(tag, 32'(q_size(k)), 32'd0);
  endtask

  task automatic cs_low(input int m);
    cs_v[m] = 1'b0;
    #(2 * HALF);
  endtask

  task automatic cs_high(input int m);
    #HALF;
    cs_v[m] = 1'b1;
    #(2 * HALF);
  endtask

  // Behavioural SPI master. It sends the top nbits of w, MSB first, and
  // returns what it sampled on MISO at each sample edge.
  task automatic spi_bits(input int m, input logic [15:0] w, input int nbits, output logic [15:0] rxw);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2) == 1;
    rxw  = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = w[15-i];
        #HALF;
        rxw = {rxw[14:0], miso_v[m]};
        sck_v[m] = ~cpol;
        #HALF;
        sck_v[m] = cpol;
      end else begin
        sck_v[m] = ~cpol;
        mosi = w[15-i];
        #HALF;
        rxw = {rxw[14:0], miso_v[m]};
        sck_v[m] = cpol;
        #HALF;
      end
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    check("reset_data",  {16'd0, data0}, 32'h0);
    check("reset_addr",  {21'd0, addr0}, 32'h7FF);
    check("reset_addr2", {30'd0, addr1}, 32'h3);
    check("reset_ws",    {28'd0, ws_v},  32'h0);
    check("reset_fa",    {28'd0, fa_v},  32'h0);
    check("reset_fe",    {28'd0, fe_v},  32'h0);
    check("reset_miso",  {28'd0, miso_v}, 32'h0);
    @(negedge clock) reset = 1'b0;
    repeat (10) @(negedge clock);

    // Mode 0: two words in one frame.
    cs_low(0);
    check("m0_frame_active", {31'd0, fa_v[0]}, 32'd1);
    spi_bits(0, 16'hA5C3, 16, rx);
    check("m0_miso_w1", {16'd0, rx}, 32'h0000);
    spi_bits(0, 16'h1234, 16, rx);
    check("m0_miso_w2", {16'd0, rx}, 32'hA5C3);
    cs_high(0);
    expect_strobe("m0_s1", 0, 0, 16'hA5C3);
    expect_strobe("m0_s2", 0, 1, 16'h1234);
    expect_no_strobe("m0_extra", 0);
    check("m0_fe",  {31'd0, fe_v[0]}, 32'd0);
    check("m0_fa_end", {31'd0, fa_v[0]}, 32'd0);

    // Modes 1, 2, 3: 0x8001 then a second word that echoes it.
    for (int m = 1; m < 4; m++) begin
      cs_low(m);
      spi_bits(m, 16'h8001, 16, rx);
      check($sformatf("m%0d_miso_w1", m), {16'd0, rx}, 32'h0000);
      spi_bits(m, 16'h4C2D, 16, rx);
      check($sformatf("m%0d_miso_w2", m), {16'd0, rx}, 32'h8001);
      cs_high(m);
      expect_strobe($sformatf("m%0d_s1", m), m, 0, 16'h8001);
      expect_strobe($sformatf("m%0d_s2", m), m, 1, 16'h4C2D);
      expect_no_strobe($sformatf("m%0d_extra", m), m);
      check($sformatf("m%0d_fe", m), {31'd0, fe_v[m]}, 32'd0);
    end

    // Truncated word: 7 bits then CS high.
    cs_low(0);
    spi_bits(0, 16'hFFFF, 7, rx);
    cs_high(0);
    expect_no_strobe("trunc_no_strobe", 0);
    check("trunc_fe", {31'd0, fe_v[0]}, 32'd1);
    check("trunc_fa", {31'd0, fa_v[0]}, 32'd0);
    cs_low(0);
    check("trunc_fe_clear", {31'd0, fe_v[0]}, 32'd0);
    check("trunc_fa_next",  {31'd0, fa_v[0]}, 32'd1);
    spi_bits(0, 16'h0F0F, 16, rx);
    check("trunc_miso_echo", {16'd0, rx}, 32'h1234);
    cs_high(0);
    expect_strobe("trunc_next", 0, 0, 16'h0F0F);
    check("trunc_next_fe", {31'd0, fe_v[0]}, 32'd0);

    // Address wrap on the 2-bit-address instance.
    cs_low(1);
    for (int i = 1; i <= 5; i++) begin
      spi_bits(1, 16'(i), 16, rx);
      if (i == 1) check("wrap_miso_w1", {16'd0, rx}, 32'h4C2D);
    end
    cs_high(1);
    expect_strobe("wrap_0", 1, 0, 16'h0001);
    expect_strobe("wrap_1", 1, 1, 16'h0002);
    expect_strobe("wrap_2", 1, 2, 16'h0003);
    expect_strobe("wrap_3", 1, 3, 16'h0004);
    expect_strobe("wrap_4", 1, 0, 16'h0005);
    expect_no_strobe("wrap_extra", 1);

    // Reset in the middle of a frame.
    cs_low(0);
    spi_bits(0, 16'hFFFF, 5, rx);
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_mid_ws",   {31'd0, ws_v[0]}, 32'd0);
    check("rst_mid_fa",   {31'd0, fa_v[0]}, 32'd0);
    reset = 1'b0;
    spi_bits(0, 16'hFFFF, 11, rx);
    #HALF;
    expect_no_strobe("rst_mid_no_strobe", 0);
    check("rst_mid_data", {16'd0, data0}, 32'h0);
    check("rst_mid_addr", {21'd0, addr0}, 32'h7FF);
    cs_high(0);
    cs_low(0);
    spi_bits(0, 16'h3C5A, 16, rx);
    check("rst_fresh_miso", {16'd0, rx}, 32'h0000);
    cs_high(0);
    expect_strobe("rst_fresh", 0, 0, 16'h3C5A);
    expect_no_strobe("rst_fresh_extra", 0);
    check("rst_fresh_fe", {31'd0, fe_v[0]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
